// File: rtl/ula_arbiter.sv
// Round-robin front end that shares one ALU between two requesters and
// returns each result, tagged with the requester id, on a single response channel.
module ula_arbiter #(
  parameter int ULA_LAT = 2,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [2:0]   req_op0,
  input  logic [2:0]   req_op1,
  input  logic         req_shift0,
  input  logic         req_shift1,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_flag,
  output logic [2:0]   ula_ctrl,
  output logic         ula_des,
  output logic [W-1:0] ula_a,
  output logic [W-1:0] ula_b,
  input  logic [W-1:0] ula_c,
  input  logic         ula_flag
);
  localparam int CW = (ULA_LAT < 1) ? 1 : $clog2(ULA_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        r_state;
  logic          r_ptr;
  logic          r_id;
  logic [CW-1:0] r_cnt;
  logic [1:0]    w_grant;
  logic          w_gid;

  // A lone requester always wins; on a tie the pointer picks.
  always_comb begin
    w_grant = req_valid;
    if (req_valid == 2'b11) w_grant = r_ptr ? 2'b10 : 2'b01;
  end

  assign w_gid     = w_grant[1];
  assign req_ready = (r_state == IDLE && !rst) ? w_grant : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_id      <= 1'b0;
      r_cnt     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_flag  <= 1'b0;
      ula_ctrl  <= 3'b000;
      ula_des   <= 1'b0;
      ula_a     <= '0;
      ula_b     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_ready) begin
            ula_ctrl <= w_gid ? req_op1    : req_op0;
            ula_des  <= w_gid ? req_shift1 : req_shift0;
            ula_a    <= w_gid ? req_a1     : req_a0;
            ula_b    <= w_gid ? req_b1     : req_b0;
            r_id     <= w_gid;
            r_ptr    <= ~w_gid;
            r_cnt    <= CW'(ULA_LAT);
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          // Operands have been stable ULA_LAT cycles: the ALU output is final.
          if (r_cnt == '0) begin
            rsp_data  <= ula_c;
            rsp_flag  <= ula_flag;
            rsp_id    <= r_id;
            rsp_valid <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_arbiter.sv
// Randomized and directed check of ula_arbiter against a transaction-level model,
// with a small behavioural ALU (2-cycle pipeline) standing in for the real one.
module tb_ula_arbiter;
  localparam int ULA_LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [2:0] t_op[2];
  logic       t_sh[2];
  logic [7:0] t_a[2];
  logic [7:0] t_b[2];
  logic       rsp_valid, rsp_ready, rsp_id, rsp_flag;
  logic [7:0] rsp_data;
  logic [2:0] ula_ctrl;
  logic       ula_des;
  logic [7:0] ula_a, ula_b, ula_c;
  logic       ula_flag;

  always #5 clk = ~clk;

  ula_arbiter #(.ULA_LAT(ULA_LAT), .W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(t_op[0]), .req_op1(t_op[1]), .req_shift0(t_sh[0]), .req_shift1(t_sh[1]),
    .req_a0(t_a[0]), .req_b0(t_b[0]), .req_a1(t_a[1]), .req_b1(t_b[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag),
    .ula_ctrl(ula_ctrl), .ula_des(ula_des), .ula_a(ula_a), .ula_b(ula_b),
    .ula_c(ula_c), .ula_flag(ula_flag)
  );

  // Returns {flag, c}; divide by zero gives flag 0 and c 0.
  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic sh,
                                       input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic signed [7:0] sa, sb;
    sa = a; sb = b; r = '0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a * b;
      3'd3: begin
        if (b == 8'd0) return 9'h000;
        r = sa / sb;
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = a;
    endcase
    if (sh) r = r << 1;
    return {1'b1, r};
  endfunction

  logic [8:0] alu_s1, alu_s2;
  always @(posedge clk) begin
    if (rst) begin
      alu_s1 <= '0;
      alu_s2 <= '0;
    end else begin
      alu_s1 <= alu_f(ula_ctrl, ula_des, ula_a, ula_b);
      alu_s2 <= alu_s1;
    end
  end
  assign ula_c    = alu_s2[7:0];
  assign ula_flag = alu_s2[8];

  int nerr = 0, ncheck = 0, cyc = 0;

  // Transaction-level model: phase 0 idle, 1 waiting on ALU, 2 holding response.
  int         m_st = 0, m_due = 0;
  logic       m_ptr = 1'b0, m_id = 1'b0;
  logic [1:0] m_acc = 2'b00;
  logic [2:0] m_ctl = '0;
  logic       m_des = 1'b0;
  logic [7:0] m_a = '0, m_b = '0;
  logic [8:0] m_res = '0;
  logic       m_rv = 1'b0, m_rid = 1'b0, m_rf = 1'b0;
  logic [7:0] m_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncheck++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] mgrant();
    if (rst || m_st != 0) return 2'b00;
    if (req_valid == 2'b11) return m_ptr ? 2'b10 : 2'b01;
    return req_valid;
  endfunction

  // Check outputs against the model, advance the model over the coming edge.
  task automatic step();
    logic [1:0] g;
    #1;
    g = mgrant();
    chk("req_ready", req_ready, g);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_id",    rsp_id,    m_rid);
    chk("rsp_data",  rsp_data,  m_rd);
    chk("rsp_flag",  rsp_flag,  m_rf);
    chk("ula_ctrl",  ula_ctrl,  m_ctl);
    chk("ula_des",   ula_des,   m_des);
    chk("ula_a",     ula_a,     m_a);
    chk("ula_b",     ula_b,     m_b);
    cyc++;
    m_acc = g;
    if (rst) begin
      m_st = 0; m_ptr = 0; m_id = 0; m_ctl = 0; m_des = 0; m_a = 0; m_b = 0;
      m_rv = 0; m_rid = 0; m_rd = 0; m_rf = 0;
    end else begin
      case (m_st)
        0: if (g != 2'b00) begin
          m_id  = g[1];
          m_ctl = t_op[m_id]; m_des = t_sh[m_id]; m_a = t_a[m_id]; m_b = t_b[m_id];
          m_res = alu_f(m_ctl, m_des, m_a, m_b);
          m_ptr = !m_id;
          m_due = cyc + ULA_LAT + 1;
          m_st  = 1;
        end
        1: if (cyc == m_due) begin
          m_st = 2; m_rv = 1; m_rid = m_id; m_rd = m_res[7:0]; m_rf = m_res[8];
        end
        default: if (rsp_ready) begin
          m_st = 0; m_rv = 0;
        end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    #1;
    while (req_ready == 2'b00 && k < 20) begin
      step(); #1; k++;
    end
  endtask

  task automatic do_op(input int id, input logic [2:0] op, input logic sh,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                       input logic ef, input int hold, input string nm);
    int lat;
    logic [7:0] d0;
    t_op[id] = op; t_sh[id] = sh; t_a[id] = a; t_b[id] = b;
    req_valid = (id == 1) ? 2'b10 : 2'b01;
    rsp_ready = 1'b0;
    wait_ready();
    chk({nm, "_grant"}, req_ready, req_valid);
    step();
    req_valid = 2'b00;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step(); lat++;
    end
    chk({nm, "_latency"}, lat, 3);
    chk({nm, "_data"}, rsp_data, ed);
    chk({nm, "_flag"}, rsp_flag, ef);
    chk({nm, "_id"}, rsp_id, id);
    d0 = rsp_data;
    repeat (hold) begin
      req_valid = 2'b11;
      step();
      chk({nm, "_hold_valid"}, rsp_valid, 1);
      chk({nm, "_hold_data"}, rsp_data, d0);
      chk({nm, "_hold_ready"}, req_ready, 0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({nm, "_drop"}, rsp_valid, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      t_op[i] = '0; t_sh[i] = 1'b0; t_a[i] = '0; t_b[i] = '0;
    end
    @(negedge clk); @(posedge clk); @(negedge clk);
    step(); step();
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ula_ctrl", ula_ctrl, 0);
    chk("rst_rsp_data", rsp_data, 0);

    // Round robin with both requesters always valid, starting from pointer 0.
    rst = 1'b0; rsp_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_ready();
      chk("rr_grant", req_ready, (g % 2 == 1) ? 2'b10 : 2'b01);
      step();
    end
    req_valid = 2'b10;
    wait_ready();
    chk("ptr_lone", req_ready, 2'b10);
    step();
    req_valid = 2'b11;
    wait_ready();
    chk("ptr_flip", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    repeat (6) step();
    rsp_ready = 1'b0;

    do_op(0, 3'b000, 1'b0, 8'd5,   8'd3, 8'd8,   1'b1, 0, "add");
    do_op(1, 3'b000, 1'b1, 8'd3,   8'd4, 8'd14,  1'b1, 0, "shift");
    do_op(0, 3'b001, 1'b0, 8'd3,   8'd5, 8'hFE,  1'b1, 0, "sub");
    do_op(1, 3'b011, 1'b0, 8'd20,  8'd0, 8'h00,  1'b0, 0, "div0");
    do_op(0, 3'b011, 1'b0, 8'hF4,  8'd4, 8'hFD,  1'b1, 0, "div");
    do_op(1, 3'b001, 1'b0, 8'd100, 8'd1, 8'd99,  1'b1, 5, "bp");
    req_valid = 2'b11;
    #1;
    chk("bp_regrant", req_ready != 2'b00, 1);
    req_valid = 2'b00;

    // Abort an operation one cycle after its handshake.
    t_op[0] = 3'b000; t_sh[0] = 1'b0; t_a[0] = 8'd7; t_b[0] = 8'd9;
    req_valid = 2'b01;
    wait_ready();
    step();
    req_valid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    t_op[1] = 3'b001; t_sh[1] = 1'b0; t_a[1] = 8'd10; t_b[1] = 8'd4;
    req_valid = 2'b10;
    #1;
    chk("abort_ready", req_ready, 2'b10);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_ula_a", ula_a, 0);
    do_op(1, 3'b001, 1'b0, 8'd10, 8'd4, 8'd6, 1'b1, 0, "after_abort");

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom % 200) == 0;
      for (int i = 0; i < 2; i++) begin
        if (!(req_valid[i] && !m_acc[i])) begin
          req_valid[i] = 1'($urandom % 2);
          t_op[i] = 3'($urandom);
          t_sh[i] = 1'($urandom);
          t_a[i]  = 8'($urandom);
          t_b[i]  = (($urandom % 5) == 0) ? 8'd0 : 8'($urandom);
        end
      end
      rsp_ready = ($urandom % 3) != 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, ncheck);
    $finish;
  end
endmodule
